// File: rtl/pipe_add_sub.sv
// ---------------------------------------------------------------------------
// pipe_add_sub
//   Pipelined W-bit adder/subtractor. The carry chain is cut into STAGES equal
//   slices of C = W/STAGES bits. Each pipeline stage ripples one slice and
//   registers the carry for the following slice. The unprocessed operand bits
//   and the finished sum bits travel with the op. Subtraction is A + ~B + c_in,
//   so the caller drives c_in=1 for a plain A-B. A valid/ready handshake with a
//   single global stall gives full backpressure.
//
// Parameters
//   W       operand/result width (W % STAGES == 0)
//   STAGES  number of carry slices = latency in cycles (1..W)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; drops every in-flight op
//   in_valid   operands valid
//   in_ready   operands accepted when in_valid & in_ready
//   a, b       operands
//   c_in       carry-in (add) / inverted borrow-in (sub)
//   sub        0: A+B+c_in   1: A+~B+c_in
//   out_valid  result valid
//   out_ready  consumer takes the result
//   sum        result, modulo 2^W
//   c_out      carry out of bit W-1 (sub: 1 = no borrow)
//   ovf        signed overflow (carry into MSB ^ carry out of MSB)
//   zero       sum == 0
// ---------------------------------------------------------------------------
module pipe_add_sub #(
  parameter int unsigned W      = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         c_out,
  output logic         ovf,
  output logic         zero
);

  localparam int unsigned C    = W / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  // Everything one op carries down the pipe. c is the carry out of the most
  // recently added slice; ovf/zero are only meaningful in the last stage.
  typedef struct packed {
    logic         v;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         c;
    logic         ovf;
    logic         zero;
  } stage_t;

  stage_t w_in;
  stage_t r_pipe [STAGES];
  logic   w_adv;

  // Global stall: the whole pipe moves only when the output slot is free or
  // being drained. Bubbles are not collapsed.
  assign w_adv    = ~r_pipe[LAST].v | out_ready;
  assign in_ready = w_adv;

  // Operand preparation at accept. Since stage 0 only loads when w_adv=1,
  // its valid bit is simply in_valid (== accept).
  always_comb begin
    w_in   = '0;
    w_in.v = in_valid;
    w_in.a = a;
    w_in.b = sub ? ~b : b;
    w_in.c = c_in;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    stage_t       w_src;
    stage_t       w_nxt;
    logic [C:0]   w_slice;

    if (k == 0) begin : g_first
      assign w_src = w_in;
    end else begin : g_rest
      assign w_src = r_pipe[k-1];
    end

    assign w_slice = {1'b0, w_src.a[k*C +: C]}
                   + {1'b0, w_src.b[k*C +: C]}
                   + {{C{1'b0}}, w_src.c};

    always_comb begin
      w_nxt             = w_src;
      w_nxt.s[k*C +: C] = w_slice[C-1:0];
      w_nxt.c           = w_slice[C];
      w_nxt.ovf         = 1'b0;
      w_nxt.zero        = 1'b0;
      if (k == LAST) begin
        // Carry into the MSB is recovered from the MSB sum bit:
        // s[W-1] = a[W-1] ^ b[W-1] ^ c[W-1].
        w_nxt.ovf  = w_slice[C] ^ w_src.a[W-1] ^ w_src.b[W-1] ^ w_slice[C-1];
        w_nxt.zero = (w_nxt.s == '0);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_pipe[k] <= '0;
      end else if (w_adv) begin
        r_pipe[k] <= w_nxt;
      end
    end
  end

  assign out_valid = r_pipe[LAST].v;
  assign sum       = r_pipe[LAST].s;
  assign c_out     = r_pipe[LAST].c;
  assign ovf       = r_pipe[LAST].ovf;
  assign zero      = r_pipe[LAST].zero;

endmodule

// File: tb/tb_pipe_add_sub.sv
// ---------------------------------------------------------------------------
// tb_pipe_add_sub
//   Four instances (STAGES = 1, 2, 4, 32; W = 32) share operands, reset and
//   out_ready. Each instance has its own in_valid gate so an op is offered to
//   an instance until it has taken it, and its own expected-result queue.
//   Expected results come from a signed/unsigned integer reference model.
// ---------------------------------------------------------------------------
module tb_pipe_add_sub;

  typedef struct {
    logic [31:0] sum;
    logic        c;
    logic        v;
    logic        z;
    int unsigned t;
  } exp_t;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        in_valid  = 1'b0;
  logic [31:0] a_r       = '0;
  logic [31:0] b_r       = '0;
  logic        cin_r     = 1'b0;
  logic        sub_r     = 1'b0;
  logic        out_ready = 1'b1;
  logic [3:0]  pend      = '0;
  logic [3:0]  iv;

  logic [3:0]  rdy_v, ovld_v, cout_v, ovf_v, zero_v;
  logic [31:0] sum_v [4];

  exp_t        sb [4][$];
  int          checks = 0;
  int          fails  = 0;
  int unsigned ncyc   = 0;
  int          rdy_mode = 0;
  bit          chk_lat  = 1'b0;
  logic [35:0] held [4];
  logic [3:0]  hold = '0;

  assign iv = {4{in_valid}} & pend;

  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  pipe_add_sub #(.W(32), .STAGES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy_v[0]),
    .a(a_r), .b(b_r), .c_in(cin_r), .sub(sub_r),
    .out_valid(ovld_v[0]), .out_ready(out_ready), .sum(sum_v[0]),
    .c_out(cout_v[0]), .ovf(ovf_v[0]), .zero(zero_v[0]));

  pipe_add_sub #(.W(32), .STAGES(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy_v[1]),
    .a(a_r), .b(b_r), .c_in(cin_r), .sub(sub_r),
    .out_valid(ovld_v[1]), .out_ready(out_ready), .sum(sum_v[1]),
    .c_out(cout_v[1]), .ovf(ovf_v[1]), .zero(zero_v[1]));

  pipe_add_sub #(.W(32), .STAGES(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(rdy_v[2]),
    .a(a_r), .b(b_r), .c_in(cin_r), .sub(sub_r),
    .out_valid(ovld_v[2]), .out_ready(out_ready), .sum(sum_v[2]),
    .c_out(cout_v[2]), .ovf(ovf_v[2]), .zero(zero_v[2]));

  pipe_add_sub #(.W(32), .STAGES(32)) u_s32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(rdy_v[3]),
    .a(a_r), .b(b_r), .c_in(cin_r), .sub(sub_r),
    .out_valid(ovld_v[3]), .out_ready(out_ready), .sum(sum_v[3]),
    .c_out(cout_v[3]), .ovf(ovf_v[3]), .zero(zero_v[3]));

  function automatic int unsigned stg_of(input int d);
    case (d)
      0:       return 1;
      1:       return 2;
      2:       return 4;
      default: return 32;
    endcase
  endfunction

  // Reference: plain integer arithmetic. Unsigned result gives sum and the
  // carry/no-borrow; signed result out of 32-bit range gives overflow.
  function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tb,
                                 input logic tc, input logic ts);
    exp_t   m;
    longint u, s;
    longint sa, sbv;
    sa  = longint'($signed(ta));
    sbv = longint'($signed(tb));
    if (!ts) begin
      u = longint'(ta) + longint'(tb) + longint'(tc);
      s = sa + sbv + longint'(tc);
    end else begin
      u = longint'(ta) - longint'(tb) - longint'(!tc);
      s = sa - sbv - longint'(!tc);
    end
    m.sum = u[31:0];
    m.c   = ts ? (u >= 0) : (u >= 64'sh1_0000_0000);
    m.v   = (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000);
    m.z   = (m.sum == 32'h0);
    m.t   = 0;
    return m;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: handshake rule, output stability under stall, in-order results.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (rdy_v[d] !== ~(ovld_v[d] & ~out_ready)) begin
          fails++;
          $display("FAIL in_ready dut%0d: got %b, expected %b", d, rdy_v[d],
                   ~(ovld_v[d] & ~out_ready));
        end
        if (hold[d]) begin
          checks++;
          if ({ovld_v[d], sum_v[d], cout_v[d], ovf_v[d], zero_v[d]} !== held[d]) begin
            fails++;
            $display("FAIL stall_hold dut%0d: got %h, expected %h", d,
                     {ovld_v[d], sum_v[d], cout_v[d], ovf_v[d], zero_v[d]}, held[d]);
          end
        end
        if (ovld_v[d] && out_ready) begin
          checks++;
          if (sb[d].size() == 0) begin
            fails++;
            $display("FAIL spurious dut%0d: got result sum=%h, expected none", d, sum_v[d]);
          end else begin
            e = sb[d].pop_front();
            if (sum_v[d] !== e.sum || cout_v[d] !== e.c || ovf_v[d] !== e.v || zero_v[d] !== e.z) begin
              fails++;
              $display("FAIL result dut%0d: got sum=%h c=%b v=%b z=%b, expected sum=%h c=%b v=%b z=%b",
                       d, sum_v[d], cout_v[d], ovf_v[d], zero_v[d], e.sum, e.c, e.v, e.z);
            end
            if (chk_lat) begin
              checks++;
              if (ncyc - e.t != stg_of(d)) begin
                fails++;
                $display("FAIL latency dut%0d: got %0d, expected %0d", d, ncyc - e.t, stg_of(d));
              end
            end
          end
        end
        hold[d] = ovld_v[d] & ~out_ready;
        held[d] = {ovld_v[d], sum_v[d], cout_v[d], ovf_v[d], zero_v[d]};
      end
    end else begin
      hold = '0;
    end
  end

  task automatic send(input logic [31:0] ta, input logic [31:0] tb,
                      input logic tc, input logic ts);
    exp_t       e;
    int         guard;
    logic [3:0] acc;
    guard    = 0;
    a_r      = ta;
    b_r      = tb;
    cin_r    = tc;
    sub_r    = ts;
    e        = model(ta, tb, tc, ts);
    pend     = '1;
    in_valid = 1'b1;
    while (pend != 0) begin
      @(negedge clk);
      acc = pend & rdy_v;
      for (int d = 0; d < 4; d++) begin
        if (acc[d]) begin
          e.t = ncyc;
          sb[d].push_back(e);
        end
      end
      @(posedge clk);
      #1;
      pend = pend & ~acc;
      guard++;
      if (pend != 0 && guard >= 200) begin
        checks++;
        fails++;
        $display("FAIL accept_timeout: pending=%b, expected 0000", pend);
        pend = '0;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) != 0 && g < 400) begin
      @(posedge clk);
      g++;
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (sb[d].size() != 0) begin
        fails++;
        $display("FAIL drain dut%0d: got %0d outstanding, expected 0", d, sb[d].size());
      end
    end
  endtask

  initial begin
    int gap;
    #12;
    for (int d = 0; d < 4; d++) begin
      checks++;
      if ({ovld_v[d], sum_v[d], cout_v[d], ovf_v[d], zero_v[d]} !== 36'h0) begin
        fails++;
        $display("FAIL reset_state dut%0d: got %h, expected 0", d,
                 {ovld_v[d], sum_v[d], cout_v[d], ovf_v[d], zero_v[d]});
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (rdy_v[d] !== 1'b1) begin
        fails++;
        $display("FAIL ready_after_reset dut%0d: got %b, expected 1", d, rdy_v[d]);
      end
    end

    // Directed single ops on an empty pipe: exact latency is checked too.
    chk_lat = 1'b1;
    send(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0); drain();
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0); drain();
    send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1); drain();
    send(32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1); drain();
    chk_lat = 1'b0;

    // Back-to-back stream with a 3-cycle consumer stall in the middle.
    fork
      begin
        for (int i = 0; i < 8; i++) send(32'(i), 32'(i), 1'b0, 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        rdy_mode = 2;
        repeat (3) @(posedge clk);
        rdy_mode = 0;
      end
    join
    drain();

    // Reset with ops in flight.
    send(32'd10, 32'd20, 1'b0, 1'b0);
    send(32'd30, 32'd40, 1'b0, 1'b0);
    send(32'd50, 32'd60, 1'b0, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) begin
      checks++;
      if ({ovld_v[d], sum_v[d], cout_v[d], ovf_v[d], zero_v[d]} !== 36'h0) begin
        fails++;
        $display("FAIL reset_midflight dut%0d: got %h, expected 0", d,
                 {ovld_v[d], sum_v[d], cout_v[d], ovf_v[d], zero_v[d]});
      end
      sb[d].delete();
    end
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    chk_lat = 1'b1;
    send(32'd1, 32'd1, 1'b0, 1'b0);
    drain();
    chk_lat = 1'b0;

    // Random operands, random gaps, random consumer backpressure.
    rdy_mode = 1;
    repeat (300) begin
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    rdy_mode = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
